ahb_mtx_arb_rr: RTL and testbench



---
 rtl/ahb_mtx_arb_pkg.sv | 32 +++
 rtl/ahb_mtx_rr_pick.sv | 29 ++
 rtl/ahb_mtx_arb_rr.sv | 124 ++++++++++++
 tb/tb_ahb_mtx_arb_rr.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_mtx_arb_pkg.sv
// Shared AHB encodings and burst-length helper for the bus-matrix output arbiter.
package ahb_mtx_arb_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HBURST encodings
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  // Beats remaining after the NONSEQ of a fixed burst; 0 for SINGLE and INCR.
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    logic [3:0] beats_m1;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats_m1 = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats_m1 = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats_m1 = 4'd15;
      default:                      beats_m1 = 4'd0;
    endcase
    return beats_m1;
  endfunction

endpackage

// File: rtl/ahb_mtx_rr_pick.sv
// Combinational rotating-priority picker: the first requesting port after
// `last` (with wrap-around) wins.
module ahb_mtx_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last,
  output logic [PORT_W-1:0]    winner,
  output logic                 any
);

  // Scan from the farthest offset down to the nearest so the nearest request overrides.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    winner = '0;
    any    = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (req[PORT_W'(idx)]) begin
        winner = PORT_W'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_mtx_arb_rr.sv
// Round-robin output-stage arbiter for one shared AHB slave port.
// Holds the grant during locked sequences and, when AHB_ARB_BURST_HOLD_EN is
// defined, for the full length of fixed-length bursts.
module ahb_mtx_arb_rr
  import ahb_mtx_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 hold_active
);

  // Reset pointer so that port 0 is first in line.
  localparam logic [PORT_W-1:0] LAST_RST = PORT_W'(NUM_PORTS - 1);

  logic [PORT_W-1:0] last;
  logic [PORT_W-1:0] pick_winner;
  logic              pick_any;
  logic [PORT_W-1:0] cur_nxt;
  logic [PORT_W-1:0] last_nxt;
  logic              no_port_nxt;
  logic              hold;
  logic              cur_active;

  assign cur_active = HSELM && (HTRANSM != HTRANS_IDLE);

  ahb_mtx_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req    (req_port),
    .last   (last),
    .winner (pick_winner),
    .any    (pick_any)
  );

`ifdef AHB_ARB_BURST_HOLD_EN
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       hold_start;
  logic       hold_cont;

  // A fixed burst starting, or a burst with more than one beat still to go.
  assign hold_start = HSELM && (HTRANSM == HTRANS_NONSEQ) && (burst_beats_m1(HBURSTM) != 4'd0);
  assign hold_cont  = (cnt > 4'd1) && ((HTRANSM == HTRANS_SEQ) || (HTRANSM == HTRANS_BUSY));
  assign hold       = hold_start || hold_cont;

  // Beat counter next state; anything outside an orderly burst clears it.
  always_comb begin
    cnt_nxt = 4'd0;
    if (HSELM) begin
      case (HTRANSM)
        HTRANS_NONSEQ: cnt_nxt = burst_beats_m1(HBURSTM);
        HTRANS_SEQ:    cnt_nxt = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
        HTRANS_BUSY:   cnt_nxt = cnt;
        default:       cnt_nxt = 4'd0;
      endcase
    end
  end

  // Beat counter and its registered non-zero flag, advanced on completed transfers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt         <= 4'd0;
      hold_active <= 1'b0;
    end else if (HREADYM) begin
      cnt         <= cnt_nxt;
      hold_active <= (cnt_nxt != 4'd0);
    end
  end
`else
  logic unused_burst;

  assign hold         = 1'b0;
  assign hold_active  = 1'b0;
  assign unused_burst = ^HBURSTM;
`endif

  // Grant decision: lock, then burst hold, then round-robin, then idle handling.
  always_comb begin
    cur_nxt     = addr_in_port;
    last_nxt    = last;
    no_port_nxt = no_port;
    if (!HMASTLOCKM) begin
      if (hold) begin
        no_port_nxt = 1'b0;
      end else if (pick_any) begin
        cur_nxt     = pick_winner;
        last_nxt    = pick_winner;
        no_port_nxt = 1'b0;
      end else if (!HSELM) begin
        no_port_nxt = 1'b1;
      end else if (!cur_active) begin
        no_port_nxt = 1'b0;
      end
      // Otherwise the current owner is mid-transfer with nobody waiting: keep all.
    end
  end

  // Grant registers, frozen while the output port is stalled.
  always_ff @(posedge HCLK or posedge HRESET) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (HRESET) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      last         <= LAST_RST;
    end else if (HREADYM) begin
      addr_in_port <= cur_nxt;
      no_port      <= no_port_nxt;
      last         <= last_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_mtx_arb_rr.sv
// Self-checking bench for ahb_mtx_arb_rr: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a
// behavioural model. Honours AHB_ARB_BURST_HOLD_EN like the design.
module tb_ahb_mtx_arb_rr;

  localparam int N  = 4;
  localparam int PW = 2;
`ifdef AHB_ARB_BURST_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] B_SINGLE  = 3'd0;
  localparam logic [2:0] B_INCR4   = 3'd3;
  localparam logic [2:0] B_INCR8   = 3'd5;
  localparam logic [2:0] B_INCR16  = 3'd7;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b0;
  logic [N-1:0]  req_port;
  logic          HREADYM;
  logic          HSELM;
  logic [1:0]    HTRANSM;
  logic [2:0]    HBURSTM;
  logic          HMASTLOCKM;
  logic [PW-1:0] addr_in_port;
  logic          no_port;
  logic          hold_active;

  int n_checks = 0;
  int n_pass   = 0;

  ahb_mtx_arb_rr #(.NUM_PORTS(N)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .req_port     (req_port),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .hold_active  (hold_active)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_cur  = 0;
  int m_last = N - 1;
  int m_left = 0;   // beats of the current fixed burst still to come
  bit m_nop  = 1'b1;
  int burst_len [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  always @(posedge HCLK or posedge HRESET) begin : model
    int  win;
    bit  found;
    bit  hold_now;
    int  len;
    int  left_nxt;
    int  reqs;
    if (HRESET) begin
      m_cur = 0; m_nop = 1'b1; m_last = N - 1; m_left = 0;
    end else if (HREADYM) begin
      reqs  = int'(req_port);
      len   = burst_len[HBURSTM];
      found = 1'b0;
      win   = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && (((reqs >> ((m_last + k) % N)) & 1) == 1)) begin
          found = 1'b1;
          win   = (m_last + k) % N;
        end
      end
      hold_now = HOLD && ((HSELM && HTRANSM == TR_NONSEQ && len > 1) ||
                          (m_left > 1 && (HTRANSM == TR_SEQ || HTRANSM == TR_BUSY)));
      if (!HSELM || HTRANSM == TR_IDLE)  left_nxt = 0;
      else if (HTRANSM == TR_NONSEQ)     left_nxt = len - 1;
      else if (HTRANSM == TR_SEQ)        left_nxt = (m_left > 0) ? m_left - 1 : 0;
      else                               left_nxt = m_left;
      if (!HOLD) left_nxt = 0;
      if (!HMASTLOCKM) begin
        if (hold_now) m_nop = 1'b0;
        else if (found) begin
          m_cur = win; m_last = win; m_nop = 1'b0;
        end else if (!HSELM) m_nop = 1'b1;
        else if (HTRANSM == TR_IDLE) m_nop = 1'b0;
      end
      m_left = left_nxt;
    end
  end

  // Per-cycle comparison on the falling edge, away from the update edge.
  always @(negedge HCLK) begin
    check("cmp_addr", int'(addr_in_port), m_cur);
    check("cmp_no_port", int'(no_port), int'(m_nop));
    check("cmp_hold", int'(hold_active), HOLD ? int'(m_left != 0) : 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [N-1:0] r, input logic rdy, input logic sel,
                      input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    req_port = r; HREADYM = rdy; HSELM = sel; HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk;
    @(posedge HCLK);
    #1;
  endtask

  logic [1:0] c_tr [4] = '{TR_NONSEQ, TR_SEQ, TR_SEQ, TR_SEQ};
  int c_hold [4] = '{2, 2, 2, 0};
  int c_rr   [4] = '{0, 2, 0, 2};
  int c_ha   [4] = '{1, 1, 1, 0};
  logic [1:0] d_tr [6] = '{TR_NONSEQ, TR_SEQ, TR_SEQ, TR_BUSY, TR_SEQ, TR_IDLE};
  int d_hold [6] = '{3, 3, 3, 3, 3, 1};
  int d_ha   [6] = '{1, 1, 1, 1, 1, 0};

  initial begin
    logic [1:0] prev_tr;
    req_port = '0; HREADYM = 1'b1; HSELM = 1'b0; HTRANSM = TR_IDLE;
    HBURSTM = B_SINGLE; HMASTLOCKM = 1'b0;
    #1 HRESET = 1'b1;
    #1;
    check("rst_addr", int'(addr_in_port), 0);
    check("rst_no_port", int'(no_port), 1);
    check("rst_hold", int'(hold_active), 0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;

    // All ports requesting: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 1'b1, TR_NONSEQ, B_SINGLE, 1'b0);
      check($sformatf("rr_all_%0d", i), int'(addr_in_port), i % N);
      check($sformatf("rr_all_nop_%0d", i), int'(no_port), 0);
    end

    // last=1, then 1001 -> 3, then 0001 -> 0.
    step(4'b0010, 1'b1, 1'b1, TR_NONSEQ, B_SINGLE, 1'b0);
    check("set_last1", int'(addr_in_port), 1);
    step(4'b1001, 1'b1, 1'b1, TR_NONSEQ, B_SINGLE, 1'b0);
    check("wrap_pick3", int'(addr_in_port), 3);
    step(4'b0001, 1'b1, 1'b1, TR_NONSEQ, B_SINGLE, 1'b0);
    check("wrap_pick0", int'(addr_in_port), 0);

    // Port 2 runs INCR4 while port 0 keeps requesting.
    step(4'b0100, 1'b1, 1'b1, TR_IDLE, B_SINGLE, 1'b0);
    check("incr4_owner", int'(addr_in_port), 2);
    for (int i = 0; i < 4; i++) begin
      step(4'b0101, 1'b1, 1'b1, c_tr[i], B_INCR4, 1'b0);
      check($sformatf("incr4_beat%0d", i + 1), int'(addr_in_port), HOLD ? c_hold[i] : c_rr[i]);
      check($sformatf("incr4_hold%0d", i + 1), int'(hold_active), HOLD ? c_ha[i] : 0);
    end

    // INCR8 by port 3 with BUSY inserted, then IDLE ends it early.
    step(4'b1000, 1'b1, 1'b1, TR_IDLE, B_SINGLE, 1'b0);
    check("incr8_owner", int'(addr_in_port), 3);
    for (int i = 0; i < 6; i++) begin
      step(4'b0010, 1'b1, 1'b1, d_tr[i], B_INCR8, 1'b0);
      check($sformatf("incr8_edge%0d", i), int'(addr_in_port), HOLD ? d_hold[i] : 1);
      check($sformatf("incr8_hold%0d", i), int'(hold_active), HOLD ? d_ha[i] : 0);
    end

    // Lock on port 1 beats round-robin; release hands over to 2.
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, 1'b1, 1'b1, TR_NONSEQ, B_SINGLE, 1'b1);
      check($sformatf("lock_%0d", i), int'(addr_in_port), 1);
    end
    step(4'b1111, 1'b1, 1'b1, TR_NONSEQ, B_SINGLE, 1'b0);
    check("unlock_grant", int'(addr_in_port), 2);

    // Idle bus deselects; stalled edges freeze everything.
    step(4'b0000, 1'b1, 1'b0, TR_IDLE, B_SINGLE, 1'b0);
    check("idle_nop", int'(no_port), 1);
    check("idle_addr", int'(addr_in_port), 2);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 1'b1, TR_NONSEQ, B_SINGLE, 1'b0);
      check($sformatf("stall_addr%0d", i), int'(addr_in_port), 2);
      check($sformatf("stall_nop%0d", i), int'(no_port), 1);
    end
    step(4'b0000, 1'b1, 1'b0, TR_IDLE, B_SINGLE, 1'b0);
    check("lost_req_nop", int'(no_port), 1);

    // Reset in the middle of an INCR16.
    step(4'b1000, 1'b1, 1'b1, TR_IDLE, B_SINGLE, 1'b0);
    check("incr16_owner", int'(addr_in_port), 3);
    step(4'b1000, 1'b1, 1'b1, TR_NONSEQ, B_INCR16, 1'b0);
    check("incr16_hold", int'(hold_active), HOLD ? 1 : 0);
    step(4'b1000, 1'b1, 1'b1, TR_SEQ, B_INCR16, 1'b0);
    step(4'b1000, 1'b1, 1'b1, TR_SEQ, B_INCR16, 1'b0);
    #2 HRESET = 1'b1;
    #1;
    check("midrst_addr", int'(addr_in_port), 0);
    check("midrst_nop", int'(no_port), 1);
    check("midrst_hold", int'(hold_active), 0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;

    // Randomized traffic, loosely burst-shaped, with occasional async resets.
    prev_tr = TR_IDLE;
    for (int i = 0; i < 4000; i++) begin
      @(negedge HCLK);
      req_port   = 4'($urandom);
      HREADYM    = ($urandom_range(0, 3) != 0);
      HSELM      = ($urandom_range(0, 7) != 0);
      HMASTLOCKM = ($urandom_range(0, 9) == 0);
      if (prev_tr != TR_IDLE && $urandom_range(0, 9) < 7) begin
        HTRANSM = ($urandom_range(0, 4) == 0) ? TR_BUSY : TR_SEQ;
      end else begin
        HTRANSM = 2'($urandom_range(0, 3));
        HBURSTM = 3'($urandom_range(0, 7));
      end
      prev_tr = HTRANSM;
      if ($urandom_range(0, 499) == 0) begin
        #2 HRESET = 1'b1;
        #1 HRESET = 1'b0;
      end
    end
    @(negedge HCLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
